regfile_port_sched: RTL and testbench

Access scheduler for the 32-entry single-mode register file. The file's one `read` control selects read or write, so it cannot serve operand fetch and writeback at once. This block arbitrates between the decode-stage read requester and the writeback write requester and sequences the file's address, data and mode lines with safe setup and hold around every write. It returns operands through a request/acknowledge handshake.

---
 rtl/regfile_port_sched.sv | 182 ++++++++++++++++++
 tb/tb_regfile_port_sched.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_port_sched.sv
// regfile_port_sched: arbitrates decode-stage operand reads against writeback
// writes on a register file with a single read/write mode line, and sequences
// index/data setup and hold around every write pulse.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// IDLE     | rf_read=1, index/data lines hold; sample and arbitrate requests
// RD       | rf_rsrc1/2 driven, rf_out1/2 captured into rd_data1/2 at the edge
// WSETUP   | rf_rdst/rf_in valid for one cycle before the mode line falls
// WRITE    | rf_read=0 for WR_HOLD cycles, timed by a down-counter
// WREL     | rf_read back to 1, index/data still held for one cycle
// ACK      | one-cycle rd_ack or wr_ack, last_grant updated, requests ignored
module regfile_port_sched #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int WR_HOLD = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_src1,
    input  logic [ADDR_W-1:0] rd_src2,
    output logic              rd_ack,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_dst,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic              busy,
    output logic              rf_read,
    output logic [ADDR_W-1:0] rf_rsrc1,
    output logic [ADDR_W-1:0] rf_rsrc2,
    output logic [ADDR_W-1:0] rf_rdst,
    output logic [DATA_W-1:0] rf_in,
    input  logic [DATA_W-1:0] rf_out1,
    input  logic [DATA_W-1:0] rf_out2
);

    localparam int CNT_W = (WR_HOLD > 1) ? $clog2(WR_HOLD) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WR_HOLD - 1);

    typedef enum logic [2:0] {
        st_idle,
        st_rd,
        st_wsetup,
        st_write,
        st_wrel,
        st_ack
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  hold_cnt;
    logic              op_wr;         // transaction in flight is a write
    logic              last_grant_wr; // 1 = last completed grant was the write side
    logic              hazard;
    logic              wr_zero;
    logic              grant_rd;
    logic              grant_wr;

    // A pending read that names the write destination must see the new value,
    // so the write goes first; index 0 is hard-wired zero and never a hazard.
    assign wr_zero = (wr_dst == '0);
    assign hazard  = !wr_zero && ((wr_dst == rd_src1) || (wr_dst == rd_src2));

    // Next-state decode and arbitration; only IDLE issues grants.
    always_comb begin
        state_nxt = state;
        grant_rd  = 1'b0;
        grant_wr  = 1'b0;
        case (state)
            st_idle: begin
                if (rd_req && wr_req) begin
                    if (hazard || !last_grant_wr) begin
                        grant_wr = 1'b1;
                    end else begin
                        grant_rd = 1'b1;
                    end
                end else if (rd_req) begin
                    grant_rd = 1'b1;
                end else if (wr_req) begin
                    grant_wr = 1'b1;
                end
                if (grant_rd) begin
                    state_nxt = st_rd;
                end else if (grant_wr) begin
                    // A write to index 0 has no effect, so it is acknowledged
                    // without ever touching the mode line.
                    state_nxt = wr_zero ? st_ack : st_wsetup;
                end
            end
            st_rd:     state_nxt = st_ack;
            st_wsetup: state_nxt = st_write;
            st_write: begin
                if (hold_cnt == '0) begin
                    state_nxt = st_wrel;
                end
            end
            st_wrel:   state_nxt = st_ack;
            st_ack:    state_nxt = st_idle;
            default:   state_nxt = st_idle;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= st_idle;
        end else begin
            state <= state_nxt;
        end
    end

    // Write-pulse timer: loaded in WSETUP, terminal count at zero ends WRITE.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt <= '0;
        end else if (state == st_wsetup) begin
            hold_cnt <= CNT_LOAD;
        end else if ((state == st_write) && (hold_cnt != '0)) begin
            hold_cnt <= hold_cnt - 1'b1;
        end
    end

    // Transaction type and round-robin history.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_wr         <= 1'b0;
            last_grant_wr <= 1'b1;
        end else begin
            if (grant_rd) begin
                op_wr <= 1'b0;
            end else if (grant_wr) begin
                op_wr <= 1'b1;
            end
            if (state == st_ack) begin
                last_grant_wr <= op_wr;
            end
        end
    end

    // Register-file index/data lines; loaded only on a grant, i.e. while
    // rf_read is 1, so they never move under a low mode line.
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_rsrc1 <= '0;
            rf_rsrc2 <= '0;
            rf_rdst  <= '0;
            rf_in    <= '0;
        end else begin
            if (grant_rd) begin
                rf_rsrc1 <= rd_src1;
                rf_rsrc2 <= rd_src2;
            end
            if (grant_wr && !wr_zero) begin
                rf_rdst <= wr_dst;
                rf_in   <= wr_data;
            end
        end
    end

    // Operand capture at the end of RD; held until the next read completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data1 <= '0;
            rd_data2 <= '0;
        end else if (state == st_rd) begin
            rd_data1 <= rf_out1;
            rd_data2 <= rf_out2;
        end
    end

    // Status and handshake outputs decoded from the registered state.
    always_comb begin
        rf_read = (state != st_write);
        busy    = (state != st_idle);
        rd_ack  = (state == st_ack) && !op_wr;
        wr_ack  = (state == st_ack) && op_wr;
    end

endmodule

// File: tb/tb_regfile_port_sched.sv
// Bench for regfile_port_sched: a behavioural register file drives rf_out1/2,
// and a transaction-level reference (shadow contents plus grant history)
// predicts grant order, latencies and returned operands.
module tb_regfile_port_sched;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 5;
    localparam int WR_HOLD = 2;

    logic              clk;
    logic              reset;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_src1;
    logic [ADDR_W-1:0] rd_src2;
    logic              rd_ack;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_dst;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;
    logic              busy;
    logic              rf_read;
    logic [ADDR_W-1:0] rf_rsrc1;
    logic [ADDR_W-1:0] rf_rsrc2;
    logic [ADDR_W-1:0] rf_rdst;
    logic [DATA_W-1:0] rf_in;
    logic [DATA_W-1:0] rf_out1;
    logic [DATA_W-1:0] rf_out2;

    int passed = 0;
    int total  = 0;

    logic [DATA_W-1:0] ref_mem [32];
    logic              ref_last_wr;

    logic [DATA_W-1:0] env_mem [32];
    logic              env_clear;

    regfile_port_sched #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .WR_HOLD(WR_HOLD)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .rd_req  (rd_req),
        .rd_src1 (rd_src1),
        .rd_src2 (rd_src2),
        .rd_ack  (rd_ack),
        .rd_data1(rd_data1),
        .rd_data2(rd_data2),
        .wr_req  (wr_req),
        .wr_dst  (wr_dst),
        .wr_data (wr_data),
        .wr_ack  (wr_ack),
        .busy    (busy),
        .rf_read (rf_read),
        .rf_rsrc1(rf_rsrc1),
        .rf_rsrc2(rf_rsrc2),
        .rf_rdst (rf_rdst),
        .rf_in   (rf_in),
        .rf_out1 (rf_out1),
        .rf_out2 (rf_out2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: writes whenever the mode line is low at a rising edge.
    always @(posedge clk) begin
        if (env_clear) begin
            for (int i = 0; i < 32; i++) env_mem[i] <= '0;
        end else if (!rf_read && rf_rdst != '0) begin
            env_mem[rf_rdst] <= rf_in;
        end
    end
    assign rf_out1 = (rf_rsrc1 == '0) ? '0 : env_mem[rf_rsrc1];
    assign rf_out2 = (rf_rsrc2 == '0) ? '0 : env_mem[rf_rsrc2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset  = 1'b1;
        rd_req = 1'b0;
        wr_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        ref_last_wr = 1'b1;
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] dst, input logic [DATA_W-1:0] data);
        int cyc = 0;
        int lows = 0;
        bit got = 0;
        bit hold_ok = 1;
        @(negedge clk);
        chk("wr_start_idle", busy, 0);
        wr_dst  = dst;
        wr_data = data;
        wr_req  = 1'b1;
        while (!got && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (!rf_read) lows++;
            if (dst != 0 && (rf_rdst !== dst || rf_in !== data)) hold_ok = 0;
            if (wr_ack) got = 1;
        end
        wr_req = 1'b0;
        chk("wr_ack_seen", 32'(got), 1);
        chk("wr_latency", 32'(cyc), (dst == 0) ? 1 : 3 + WR_HOLD);
        chk("wr_low_cycles", 32'(lows), (dst == 0) ? 0 : WR_HOLD);
        chk("wr_busy_at_ack", busy, 1);
        if (dst != 0) begin
            chk("wr_lines_held", 32'(hold_ok), 1);
            ref_mem[dst] = data;
        end
        ref_last_wr = 1'b1;
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] s1, input logic [ADDR_W-1:0] s2);
        int cyc = 0;
        bit got = 0;
        @(negedge clk);
        chk("rd_start_idle", busy, 0);
        rd_src1 = s1;
        rd_src2 = s2;
        rd_req  = 1'b1;
        while (!got && cyc < 60) begin
            @(negedge clk);
            cyc++;
            chk("rd_rf_read_high", rf_read, 1);
            if (rd_ack) got = 1;
        end
        rd_req = 1'b0;
        chk("rd_ack_seen", 32'(got), 1);
        chk("rd_latency", 32'(cyc), 2);
        chk("rd_data1", rd_data1, ref_mem[s1]);
        chk("rd_data2", rd_data2, ref_mem[s2]);
        ref_last_wr = 1'b0;
    endtask

    task automatic do_both(input logic [ADDR_W-1:0] s1, input logic [ADDR_W-1:0] s2,
                           input logic [ADDR_W-1:0] dst, input logic [DATA_W-1:0] data);
        int cyc = 0;
        bit rd_done = 0;
        bit wr_done = 0;
        bit first_set = 0;
        bit first_wr = 0;
        bit exp_wr_first;
        exp_wr_first = ((dst != 0) && (dst == s1 || dst == s2)) || !ref_last_wr;
        @(negedge clk);
        chk("both_start_idle", busy, 0);
        rd_src1 = s1;
        rd_src2 = s2;
        wr_dst  = dst;
        wr_data = data;
        rd_req  = 1'b1;
        wr_req  = 1'b1;
        while (!(rd_done && wr_done) && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (wr_ack) begin
                if (!first_set) begin
                    first_set = 1;
                    first_wr  = 1;
                end
                if (dst != 0) ref_mem[dst] = data;
                wr_req  = 1'b0;
                wr_done = 1;
            end
            if (rd_ack) begin
                if (!first_set) begin
                    first_set = 1;
                    first_wr  = 0;
                end
                chk("both_rd_data1", rd_data1, ref_mem[s1]);
                chk("both_rd_data2", rd_data2, ref_mem[s2]);
                rd_req  = 1'b0;
                rd_done = 1;
            end
        end
        rd_req = 1'b0;
        wr_req = 1'b0;
        chk("both_completed", 32'(rd_done && wr_done), 1);
        chk("both_write_first", 32'(first_wr), 32'(exp_wr_first));
        ref_last_wr = !exp_wr_first;
    endtask

    task automatic reset_mid_write();
        @(negedge clk);
        wr_dst  = 5'd4;
        wr_data = 32'hDEAD_0004;
        wr_req  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_write_low", rf_read, 0);
        reset  = 1'b1;
        wr_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_rf_read", rf_read, 1);
        chk("rst_busy", busy, 0);
        chk("rst_no_wr_ack", wr_ack, 0);
        chk("rst_rf_rdst", rf_rdst, 0);
        ref_last_wr = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) ref_mem[i] = '0;
        ref_last_wr = 1'b1;
        env_clear = 1'b1;
        reset   = 1'b1;
        rd_req  = 1'b0;
        wr_req  = 1'b0;
        rd_src1 = '0;
        rd_src2 = '0;
        wr_dst  = '0;
        wr_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        env_clear = 1'b0;
        reset = 1'b0;

        // Idle after reset.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_rf_read", rf_read, 1);
            chk("idle_rd_ack", rd_ack, 0);
            chk("idle_wr_ack", wr_ack, 0);
            chk("idle_busy", busy, 0);
            chk("idle_rf_rsrc1", rf_rsrc1, 0);
            chk("idle_rf_rsrc2", rf_rsrc2, 0);
            chk("idle_rf_rdst", rf_rdst, 0);
            chk("idle_rf_in", rf_in, 0);
            chk("idle_rd_data1", rd_data1, 0);
        end

        do_write(5'd3, 32'h0000_0007);
        do_read(5'd3, 5'd0);
        do_both(5'd5, 5'd3, 5'd5, 32'h0000_000A);

        // Round-robin from a fresh reset: read, write, then read, write.
        do_reset();
        do_both(5'd1, 5'd2, 5'd9, 32'h1234_5678);
        do_both(5'd1, 5'd2, 5'd9, 32'h9ABC_DEF0);

        do_write(5'd0, 32'hFFFF_FFFF);
        do_read(5'd0, 5'd9);

        reset_mid_write();
        do_write(5'd4, 32'h0000_0044);
        do_read(5'd4, 5'd3);

        // Randomized mix with small indices so hazards and ties are common.
        for (int n = 0; n < 60; n++) begin
            int kind;
            logic [ADDR_W-1:0] a, b, d;
            logic [DATA_W-1:0] v;
            kind = $urandom_range(0, 2);
            a = ADDR_W'($urandom_range(0, 7));
            b = ADDR_W'($urandom_range(0, 7));
            d = ADDR_W'($urandom_range(0, 7));
            v = $urandom;
            case (kind)
                0:       do_write(d, v);
                1:       do_read(a, b);
                default: do_both(a, b, d, v);
            endcase
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
